// File: rtl/fu_complete_arbiter.sv
// fu_complete_arbiter: tracks per-FU occupancy (IDLE/BUSY/DONE), buffers one
// finished result per FU, and broadcasts up to three of them per cycle on the
// CDB using a round-robin scan that starts at rr_ptr.
module fu_complete_arbiter #(
  parameter int unsigned NUM_FU = 8,
  parameter int unsigned PRW    = 6,
  parameter int unsigned XLEN   = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   squash,
  input  logic [NUM_FU-1:0]      issue_valid,
  input  logic [NUM_FU-1:0]      fu_done,
  input  logic [NUM_FU*PRW-1:0]  fu_dest_pr,
  input  logic [NUM_FU*XLEN-1:0] fu_result,
  output logic [NUM_FU-1:0]      fu_ready,
  output logic [2:0]             cdb_valid,
  output logic [3*PRW-1:0]       cdb_t,
  output logic [3*XLEN-1:0]      cdb_value
);

  localparam int unsigned LANES = 3;
  localparam int unsigned PTRW  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [PTRW:0] NUM_FU_W = NUM_FU[PTRW:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } slot_state_t;

  slot_state_t       state    [NUM_FU];
  logic [PRW-1:0]    hold_tag [NUM_FU];
  logic [XLEN-1:0]   hold_val [NUM_FU];
  logic [PTRW-1:0]   rr_ptr;

  logic [NUM_FU-1:0] grant;
  logic [LANES-1:0]  lane_valid;
  logic [PTRW-1:0]   lane_sel [LANES];
  logic [PTRW-1:0]   next_ptr;

  // FU ready is a pure decode of the slot state register
  always_comb begin
    fu_ready = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (state[i] == S_IDLE);
    end
  end

  // Round-robin scan of DONE slots from rr_ptr; first three found get lanes 0..2
  always_comb begin
    logic [PTRW:0]   scan_sum;
    logic [PTRW-1:0] scan_pos;
    logic [PTRW-1:0] last_grant;
    logic [PTRW:0]   ptr_sum;
    logic [1:0]      lane_cnt;

    grant      = '0;
    lane_valid = '0;
    lane_sel   = '{default: '0};
    scan_sum   = '0;
    scan_pos   = '0;
    last_grant = '0;
    lane_cnt   = '0;

    for (int unsigned k = 0; k < NUM_FU; k++) begin
      scan_sum = {1'b0, rr_ptr} + k[PTRW:0];
      if (scan_sum >= NUM_FU_W) begin
        scan_sum = scan_sum - NUM_FU_W;
      end
      scan_pos = scan_sum[PTRW-1:0];
      if ((state[scan_pos] == S_DONE) && (lane_cnt != 2'd3)) begin
        lane_sel[lane_cnt]   = scan_pos;
        lane_valid[lane_cnt] = 1'b1;
        grant[scan_pos]      = 1'b1;
        last_grant           = scan_pos;
        lane_cnt             = lane_cnt + 2'd1;
      end
    end

    // Pointer resumes one past the last granted slot, wrapping at NUM_FU
    ptr_sum = {1'b0, last_grant} + {{PTRW{1'b0}}, 1'b1};
    if (ptr_sum >= NUM_FU_W) begin
      ptr_sum = '0;
    end
    next_ptr = ptr_sum[PTRW-1:0];
  end

  // Slot FSMs, holding registers, round-robin pointer and registered CDB lanes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= '{default: S_IDLE};
      hold_tag  <= '{default: '0};
      hold_val  <= '{default: '0};
      rr_ptr    <= '0;
      cdb_valid <= '0;
      cdb_t     <= '0;
      cdb_value <= '0;
    end else if (squash) begin
      // Flush wins over issue, completion and grant in the same cycle
      state     <= '{default: S_IDLE};
      rr_ptr    <= '0;
      cdb_valid <= '0;
      cdb_t     <= '0;
      cdb_value <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        case (state[i])
          S_IDLE: begin
            if (issue_valid[i]) begin
              state[i] <= S_BUSY;
            end
          end
          S_BUSY: begin
            if (fu_done[i]) begin
              hold_tag[i] <= fu_dest_pr[i*PRW +: PRW];
              hold_val[i] <= fu_result[i*XLEN +: XLEN];
              state[i]    <= S_DONE;
            end
          end
          S_DONE: begin
            if (grant[i]) begin
              state[i] <= S_IDLE;
            end
          end
          default: state[i] <= S_IDLE;
        endcase
      end

      // Unused lanes carry tag 0 so a valid-blind tag compare cannot misfire
      for (int unsigned l = 0; l < LANES; l++) begin
        if (lane_valid[l]) begin
          cdb_t[l*PRW +: PRW]       <= hold_tag[lane_sel[l]];
          cdb_value[l*XLEN +: XLEN] <= hold_val[lane_sel[l]];
        end else begin
          cdb_t[l*PRW +: PRW]       <= '0;
          cdb_value[l*XLEN +: XLEN] <= '0;
        end
      end
      cdb_valid <= lane_valid;

      if (|grant) begin
        rr_ptr <= next_ptr;
      end
    end
  end

  // Protocol checks: issue only into IDLE slots, completion only from BUSY slots
  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_proto
    a_issue_idle: assert property (@(posedge clock) disable iff (reset || squash)
      issue_valid[gi] |-> (state[gi] == S_IDLE));
    a_done_busy: assert property (@(posedge clock) disable iff (reset || squash)
      fu_done[gi] |-> (state[gi] == S_BUSY));
  end

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Directed bench for fu_complete_arbiter: occupancy, 3-lane round-robin CDB
// broadcast, wrap-around, squash and asynchronous reset.
module tb_fu_complete_arbiter;

  localparam int unsigned NUM_FU = 8;
  localparam int unsigned PRW    = 6;
  localparam int unsigned XLEN   = 32;

  logic                   clock;
  logic                   reset;
  logic                   squash;
  logic [NUM_FU-1:0]      issue_valid;
  logic [NUM_FU-1:0]      fu_done;
  logic [NUM_FU*PRW-1:0]  fu_dest_pr;
  logic [NUM_FU*XLEN-1:0] fu_result;
  logic [NUM_FU-1:0]      fu_ready;
  logic [2:0]             cdb_valid;
  logic [3*PRW-1:0]       cdb_t;
  logic [3*XLEN-1:0]      cdb_value;

  int tests;
  int failed;

  fu_complete_arbiter #(
    .NUM_FU (NUM_FU),
    .PRW    (PRW),
    .XLEN   (XLEN)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .squash      (squash),
    .issue_valid (issue_valid),
    .fu_done     (fu_done),
    .fu_dest_pr  (fu_dest_pr),
    .fu_result   (fu_result),
    .fu_ready    (fu_ready),
    .cdb_valid   (cdb_valid),
    .cdb_t       (cdb_t),
    .cdb_value   (cdb_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_done(input int slot, input logic [PRW-1:0] tag, input logic [XLEN-1:0] val);
    fu_dest_pr[slot*PRW +: PRW]  = tag;
    fu_result[slot*XLEN +: XLEN] = val;
  endtask

  initial begin
    tests       = 0;
    failed      = 0;
    reset       = 1'b1;
    squash      = 1'b0;
    issue_valid = '0;
    fu_done     = '0;
    fu_dest_pr  = '0;
    fu_result   = '0;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("reset_ready",  128'(fu_ready),  128'(8'hFF));
    check("reset_valid",  128'(cdb_valid), 128'(3'b000));
    check("reset_tags",   128'(cdb_t),     128'(18'd0));
    check("reset_values", 128'(cdb_value), 128'(96'd0));
    check("reset_rr_ptr", 128'(dut.rr_ptr), 128'(3'd0));

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_ready", 128'(fu_ready),  128'(8'hFF));
      check("idle_valid", 128'(cdb_valid), 128'(3'b000));
      check("idle_tags",  128'(cdb_t),     128'(18'd0));
    end

    // Single ALU: issue in cycle 1, done in cycle 3, broadcast in cycle 5
    issue_valid = 8'h01;
    tick();
    issue_valid = '0;
    check("alu_ready_c2", 128'(fu_ready), 128'(8'hFE));
    tick();
    check("alu_ready_c3", 128'(fu_ready), 128'(8'hFE));
    set_done(0, 6'd5, 32'hDEAD_BEEF);
    fu_done = 8'h01;
    tick();
    fu_done = '0;
    check("alu_ready_c4", 128'(fu_ready),  128'(8'hFE));
    check("alu_valid_c4", 128'(cdb_valid), 128'(3'b000));
    tick();
    check("alu_valid_c5", 128'(cdb_valid), 128'(3'b001));
    check("alu_tag_c5",   128'(cdb_t),     128'(18'd5));
    check("alu_value_c5", 128'(cdb_value), 128'({64'd0, 32'hDEAD_BEEF}));
    check("alu_ready_c5", 128'(fu_ready),  128'(8'hFF));
    check("alu_rr_ptr",   128'(dut.rr_ptr), 128'(3'd1));
    tick();
    check("alu_valid_c6", 128'(cdb_valid), 128'(3'b000));
    check("alu_tag_c6",   128'(cdb_t),     128'(18'd0));

    // Squash with nothing pending brings rr_ptr back to 0
    squash = 1'b1;
    tick();
    squash = 1'b0;
    check("sq0_rr_ptr", 128'(dut.rr_ptr), 128'(3'd0));

    // Five simultaneous completions: slots 0,2,3,5,7 with tags 1,3,4,6,8
    issue_valid = 8'hAD;
    tick();
    issue_valid = '0;
    check("five_ready_busy", 128'(fu_ready), 128'(8'h52));
    set_done(0, 6'd1, 32'h0000_0101);
    set_done(2, 6'd3, 32'h0000_0303);
    set_done(3, 6'd4, 32'h0000_0404);
    set_done(5, 6'd6, 32'h0000_0606);
    set_done(7, 6'd8, 32'h0000_0808);
    fu_done = 8'hAD;
    tick();
    fu_done = '0;
    check("five_valid_pre", 128'(cdb_valid), 128'(3'b000));
    tick();
    check("five_valid_1", 128'(cdb_valid), 128'(3'b111));
    check("five_tags_1",  128'(cdb_t),     128'({6'd4, 6'd3, 6'd1}));
    check("five_vals_1",  128'(cdb_value), 128'({32'h0000_0404, 32'h0000_0303, 32'h0000_0101}));
    check("five_rr_1",    128'(dut.rr_ptr), 128'(3'd4));
    check("five_ready_1", 128'(fu_ready),  128'(8'h5F));
    tick();
    check("five_valid_2", 128'(cdb_valid), 128'(3'b011));
    check("five_tags_2",  128'(cdb_t),     128'({6'd0, 6'd8, 6'd6}));
    check("five_vals_2",  128'(cdb_value), 128'({32'd0, 32'h0000_0808, 32'h0000_0606}));
    check("five_rr_2",    128'(dut.rr_ptr), 128'(3'd0));
    check("five_ready_2", 128'(fu_ready),  128'(8'hFF));
    tick();
    check("five_valid_3", 128'(cdb_valid), 128'(3'b000));

    // Move rr_ptr to 6 by granting slot 5 alone
    issue_valid = 8'h20;
    tick();
    issue_valid = '0;
    set_done(5, 6'd9, 32'h0000_0909);
    fu_done = 8'h20;
    tick();
    fu_done = '0;
    tick();
    check("wrap_setup_valid", 128'(cdb_valid), 128'(3'b001));
    check("wrap_setup_tag",   128'(cdb_t),     128'(18'd9));
    check("wrap_setup_rr",    128'(dut.rr_ptr), 128'(3'd6));

    // Wrap-around: DONE slots 1 and 7 with rr_ptr=6 -> slot 7 first
    issue_valid = 8'h82;
    tick();
    issue_valid = '0;
    set_done(1, 6'd11, 32'h0000_1111);
    set_done(7, 6'd13, 32'h0000_1313);
    fu_done = 8'h82;
    tick();
    fu_done = '0;
    check("wrap_rr_hold", 128'(dut.rr_ptr), 128'(3'd6));
    check("wrap_valid_0", 128'(cdb_valid),  128'(3'b000));
    tick();
    check("wrap_valid", 128'(cdb_valid), 128'(3'b011));
    check("wrap_tags",  128'(cdb_t),     128'({6'd0, 6'd11, 6'd13}));
    check("wrap_vals",  128'(cdb_value), 128'({32'd0, 32'h0000_1111, 32'h0000_1313}));
    check("wrap_rr",    128'(dut.rr_ptr), 128'(3'd2));

    // Destination tag 0 is still broadcast as valid
    issue_valid = 8'h40;
    tick();
    issue_valid = '0;
    set_done(6, 6'd0, 32'h0000_1234);
    fu_done = 8'h40;
    tick();
    fu_done = '0;
    tick();
    check("zero_tag_valid", 128'(cdb_valid), 128'(3'b001));
    check("zero_tag_tag",   128'(cdb_t),     128'(18'd0));
    check("zero_tag_value", 128'(cdb_value), 128'({64'd0, 32'h0000_1234}));
    check("zero_tag_rr",    128'(dut.rr_ptr), 128'(3'd7));

    // Squash with slot 2 DONE and slot 5 BUSY
    issue_valid = 8'h24;
    tick();
    issue_valid = '0;
    set_done(2, 6'd20, 32'h0000_2020);
    fu_done = 8'h04;
    tick();
    fu_done = '0;
    squash  = 1'b1;
    tick();
    squash  = 1'b0;
    check("squash_ready", 128'(fu_ready),  128'(8'hFF));
    check("squash_valid", 128'(cdb_valid), 128'(3'b000));
    check("squash_tags",  128'(cdb_t),     128'(18'd0));
    check("squash_rr",    128'(dut.rr_ptr), 128'(3'd0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("squash_no_bcast", 128'(cdb_valid), 128'(3'b000));
    end

    // Asynchronous reset mid-cycle while three slots remain DONE
    issue_valid = 8'h3F;
    tick();
    issue_valid = '0;
    set_done(0, 6'd30, 32'h0000_3030);
    set_done(1, 6'd31, 32'h0000_3131);
    set_done(2, 6'd32, 32'h0000_3232);
    set_done(3, 6'd33, 32'h0000_3333);
    set_done(4, 6'd34, 32'h0000_3434);
    set_done(5, 6'd35, 32'h0000_3535);
    fu_done = 8'h3F;
    tick();
    fu_done = '0;
    tick();
    check("arst_pre_valid", 128'(cdb_valid), 128'(3'b111));
    check("arst_pre_tags",  128'(cdb_t),     128'({6'd32, 6'd31, 6'd30}));
    check("arst_pre_ready", 128'(fu_ready),  128'(8'hC7));
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid",  128'(cdb_valid), 128'(3'b000));
    check("arst_tags",   128'(cdb_t),     128'(18'd0));
    check("arst_values", 128'(cdb_value), 128'(96'd0));
    check("arst_ready",  128'(fu_ready),  128'(8'hFF));
    check("arst_rr",     128'(dut.rr_ptr), 128'(3'd0));
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("arst_no_bcast", 128'(cdb_valid), 128'(3'b000));
      check("arst_ready_hold", 128'(fu_ready), 128'(8'hFF));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
